// File: rtl/eon_pkg.sv
// Shared decode-stage types: RV32I opcodes, control bundle, ID/EX register.
// Imported by the regfile and the decode stage.
package eon_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_src_imm;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b;
    logic [6:0]      opcode;
    ctrl_t           ctrl;
    logic            valid;
  } id_ex_t;

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file: two async reads, one sync write.
// x0 reads zero; a same-cycle WB write is bypassed to the readers.
module id_regfile
  import eon_pkg::*;
(
  input  logic            clk,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] mem [1:31];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) mem[wa] <= wd;
  end

  always_comb begin
    rd1 = '0;
    if (ra1 == 5'd0) rd1 = '0;
    else if (we && wa == ra1) rd1 = wd;
    else rd1 = mem[ra1];
  end

  always_comb begin
    rd2 = '0;
    if (ra2 == 5'd0) rd2 = '0;
    else if (we && wa == ra2) rd2 = wd;
    else rd2 = mem[ra2];
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: regfile read, immediate/control decode,
// load-use hazard bubble and the ID/EX pipeline register.
module id_stage
  import eon_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instructionIn,
  input  logic [XLEN-1:0] pcIn,
  input  logic            flush,
  input  logic            stallIn,
  input  logic            wbWriteEn,
  input  logic [4:0]      wbRd,
  input  logic [XLEN-1:0] wbData,
  output logic            stallOut,
  output logic [XLEN-1:0] pcOut,
  output logic [XLEN-1:0] rs1Data,
  output logic [XLEN-1:0] rs2Data,
  output logic [XLEN-1:0] immOut,
  output logic [4:0]      rs1Out,
  output logic [4:0]      rs2Out,
  output logic [4:0]      rdOut,
  output logic [2:0]      funct3Out,
  output logic            funct7bOut,
  output logic [6:0]      opcodeOut,
  output logic            regWrite,
  output logic            memRead,
  output logic            memWrite,
  output logic            branch,
  output logic            jump,
  output logic            aluSrcImm,
  output logic            validOut,
  output logic            illegalOut
);

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, rd;
  logic [XLEN-1:0] rd1, rd2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] imm;
  ctrl_t  ctrl;
  logic   uses1, uses2, load_use;
  id_ex_t d, q;

  assign ins = instructionIn;
  assign opc = ins[6:0];
  assign rd  = ins[11:7];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  id_regfile u_rf (
    .clk (clk),
    .ra1 (rs1),
    .ra2 (rs2),
    .we  (wbWriteEn),
    .wa  (wbRd),
    .wd  (wbData),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_comb begin
    ctrl  = '0;
    imm   = '0;
    uses1 = 1'b0;
    uses2 = 1'b0;
    unique case (1'b1)
      opc == OP_LOAD: begin
        ctrl.reg_write   = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        imm   = imm_i;
        uses1 = 1'b1;
      end
      opc == OP_STORE: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        imm   = imm_s;
        uses1 = 1'b1;
        uses2 = 1'b1;
      end
      opc == OP_IMM: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        imm   = imm_i;
        uses1 = 1'b1;
      end
      opc == OP_OP: begin
        ctrl.reg_write = 1'b1;
        uses1 = 1'b1;
        uses2 = 1'b1;
      end
      opc == OP_BRANCH: begin
        ctrl.branch = 1'b1;
        imm   = imm_b;
        uses1 = 1'b1;
        uses2 = 1'b1;
      end
      opc == OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        imm = imm_j;
      end
      opc == OP_JALR: begin
        ctrl.reg_write   = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        imm   = imm_i;
        uses1 = 1'b1;
      end
      opc == OP_LUI, opc == OP_AUIPC: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        imm = imm_u;
      end
      opc == OP_SYSTEM, opc == OP_FENCE: begin
        imm = imm_i;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    if (rd == 5'd0) ctrl.reg_write = 1'b0;
  end

  // Hazard only against the load sitting in our own ID/EX register
  assign load_use = q.valid && q.ctrl.mem_read && q.rd != 5'd0 &&
                    ((q.rd == rs1 && uses1) || (q.rd == rs2 && uses2));

  assign stallOut = (load_use || stallIn) && !flush;

  always_comb begin
    d          = '0;
    d.pc       = pcIn;
    d.rs1_data = rd1;
    d.rs2_data = rd2;
    d.imm      = imm;
    d.rs1      = rs1;
    d.rs2      = rs2;
    d.rd       = rd;
    d.funct3   = ins[14:12];
    d.funct7b  = ins[30];
    d.opcode   = opc;
    d.ctrl     = ctrl;
    d.valid    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)         q <= '0;
    else if (flush)    q <= '0;
    else if (stallIn)  q <= q;
    else if (load_use) q <= '0;
    else               q <= d;
  end

  assign pcOut      = q.pc;
  assign rs1Data    = q.rs1_data;
  assign rs2Data    = q.rs2_data;
  assign immOut     = q.imm;
  assign rs1Out     = q.rs1;
  assign rs2Out     = q.rs2;
  assign rdOut      = q.rd;
  assign funct3Out  = q.funct3;
  assign funct7bOut = q.funct7b;
  assign opcodeOut  = q.opcode;
  assign regWrite   = q.ctrl.reg_write;
  assign memRead    = q.ctrl.mem_read;
  assign memWrite   = q.ctrl.mem_write;
  assign branch     = q.ctrl.branch;
  assign jump       = q.ctrl.jump;
  assign aluSrcImm  = q.ctrl.alu_src_imm;
  assign illegalOut = q.ctrl.illegal;
  assign validOut   = q.valid;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed cases then random stream,
// checked against a behavioural RV32I decode model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instructionIn = 32'h13;
  logic [31:0] pcIn = '0;
  logic        flush = 1'b0;
  logic        stallIn = 1'b0;
  logic        wbWriteEn = 1'b0;
  logic [4:0]  wbRd = '0;
  logic [31:0] wbData = '0;
  logic        stallOut;
  logic [31:0] pcOut, rs1Data, rs2Data, immOut;
  logic [4:0]  rs1Out, rs2Out, rdOut;
  logic [2:0]  funct3Out;
  logic        funct7bOut;
  logic [6:0]  opcodeOut;
  logic        regWrite, memRead, memWrite, branch, jump;
  logic        aluSrcImm, validOut, illegalOut;

  id_stage dut (
    .clk(clk), .reset(reset),
    .instructionIn(instructionIn), .pcIn(pcIn),
    .flush(flush), .stallIn(stallIn),
    .wbWriteEn(wbWriteEn), .wbRd(wbRd), .wbData(wbData),
    .stallOut(stallOut), .pcOut(pcOut),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .immOut(immOut),
    .rs1Out(rs1Out), .rs2Out(rs2Out), .rdOut(rdOut),
    .funct3Out(funct3Out), .funct7bOut(funct7bOut),
    .opcodeOut(opcodeOut), .regWrite(regWrite),
    .memRead(memRead), .memWrite(memWrite),
    .branch(branch), .jump(jump), .aluSrcImm(aluSrcImm),
    .validOut(validOut), .illegalOut(illegalOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [6:0]  op;
    logic        rw, mr, mw, br, jp, asi, valid, ill;
    bit          imm_care, fld_care;
  } exp_t;

  typedef struct {
    exp_t s;
    logic stall;
  } rec_t;

  rec_t        sb[$];
  logic [31:0] regs [32];
  exp_t        cur;
  logic        last_stall = 1'b0;
  logic [31:0] pcv = '0;
  int          errors = 0;
  int          checks = 0;

  function automatic exp_t zero_e(bit care);
    exp_t e;
    e.pc = '0; e.r1d = '0; e.r2d = '0; e.imm = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.f3 = '0;
    e.f7 = 1'b0; e.op = '0;
    e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0;
    e.jp = 0; e.asi = 0; e.valid = 0; e.ill = 0;
    e.imm_care = care; e.fld_care = care;
    return e;
  endfunction

  function automatic exp_t decode(logic [31:0] i, logic [31:0] p,
                                  logic [31:0] a, logic [31:0] b);
    exp_t e = zero_e(1);
    e.pc = p; e.r1d = a; e.r2d = b;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.f3 = i[14:12]; e.f7 = i[30]; e.op = i[6:0];
    e.valid = 1;
    case (i[6:0])
      7'h03: begin
        e.rw = 1; e.mr = 1; e.asi = 1;
        e.imm = 32'($signed(i[31:20]));
      end
      7'h23: begin
        e.mw = 1; e.asi = 1;
        e.imm = 32'($signed({i[31:25], i[11:7]}));
      end
      7'h13: begin
        e.rw = 1; e.asi = 1;
        e.imm = 32'($signed(i[31:20]));
      end
      7'h33: begin e.rw = 1; e.imm_care = 0; end
      7'h63: begin
        e.br = 1;
        e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h6F: begin
        e.rw = 1; e.jp = 1;
        e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'h67: begin
        e.rw = 1; e.jp = 1; e.asi = 1;
        e.imm = 32'($signed(i[31:20]));
      end
      7'h37, 7'h17: begin
        e.rw = 1; e.asi = 1;
        e.imm = {i[31:12], 12'h000};
      end
      7'h73, 7'h0F: e.imm_care = 0;
      default: begin e.ill = 1; e.imm_care = 0; end
    endcase
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  function automatic logic [31:0] rd_reg(logic [4:0] x, logic we,
                                         logic [4:0] wa, logic [31:0] wd);
    if (x == 0) return 32'h0;
    if (we && wa == x) return wd;
    return regs[x];
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rd, logic [4:0] a,
                                        logic [4:0] b);
    return {7'h00, b, a, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] a,
                                        logic [2:0] f3, logic [4:0] rd,
                                        logic [6:0] op);
    return {im, a, f3, rd, op};
  endfunction

  task automatic step(input logic [31:0] ins, input logic [31:0] p,
                      input logic fl, input logic st, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic rst);
    logic u1, u2, lu, es;
    rec_t r;
    exp_t nx;
    @(posedge clk);
    #2;
    reset = rst; instructionIn = ins; pcIn = p;
    flush = fl; stallIn = st;
    wbWriteEn = we; wbRd = wa; wbData = wd;
    u1 = ins[6:0] inside {7'h33, 7'h13, 7'h23, 7'h63, 7'h67, 7'h03};
    u2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
    lu = cur.valid && cur.mr && cur.rd != 0 &&
         ((cur.rd == ins[19:15] && u1) || (cur.rd == ins[24:20] && u2));
    es = (lu || st) && !fl;
    r.s = cur; r.stall = es;
    sb.push_back(r);
    if (rst) nx = zero_e(1);
    else if (fl) nx = zero_e(0);
    else if (st) nx = cur;
    else if (lu) nx = zero_e(0);
    else nx = decode(ins, p, rd_reg(ins[19:15], we, wa, wd),
                     rd_reg(ins[24:20], we, wa, wd));
    if (we && wa != 0) regs[wa] = wd;
    cur = nx;
    last_stall = es;
  endtask

  task automatic issue(input logic [31:0] ins, input logic fl,
                       input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
    int n = 0;
    step(ins, pcv, fl, 1'b0, we, wa, wd, 1'b0);
    while (last_stall && n < 6) begin
      step(ins, pcv, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      n++;
    end
    pcv += 4;
  endtask

  // Monitor: pops one expectation per cycle, just before the next edge
  initial begin
    rec_t r;
    logic ok;
    forever begin
      @(posedge clk);
      #8;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        checks++;
        if (stallOut !== r.stall) begin
          errors++;
          $display("FAIL stallOut t=%0t got=%b exp=%b",
                   $time, stallOut, r.stall);
        end
        checks++;
        ok = validOut === r.s.valid && illegalOut === r.s.ill &&
             regWrite === r.s.rw && memRead === r.s.mr &&
             memWrite === r.s.mw && branch === r.s.br &&
             jump === r.s.jp;
        if (r.s.fld_care)
          ok = ok && aluSrcImm === r.s.asi && pcOut === r.s.pc &&
               rs1Data === r.s.r1d && rs2Data === r.s.r2d &&
               rs1Out === r.s.rs1 && rs2Out === r.s.rs2 &&
               rdOut === r.s.rd && funct3Out === r.s.f3 &&
               funct7bOut === r.s.f7 && opcodeOut === r.s.op;
        if (r.s.imm_care) ok = ok && immOut === r.s.imm;
        if (!ok) begin
          errors++;
          $display({"FAIL idex t=%0t got v%b il%b rw%b mr%b mw%b br%b ",
                    "jp%b as%b pc%h a%h b%h im%h rd%0d op%h | exp v%b ",
                    "il%b rw%b mr%b mw%b br%b jp%b as%b pc%h a%h b%h ",
                    "im%h rd%0d op%h"},
                   $time, validOut, illegalOut, regWrite, memRead,
                   memWrite, branch, jump, aluSrcImm, pcOut, rs1Data,
                   rs2Data, immOut, rdOut, opcodeOut,
                   r.s.valid, r.s.ill, r.s.rw, r.s.mr, r.s.mw, r.s.br,
                   r.s.jp, r.s.asi, r.s.pc, r.s.r1d, r.s.r2d, r.s.imm,
                   r.s.rd, r.s.op);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  logic [6:0] ops [13] = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h6F,
                           7'h67, 7'h37, 7'h17, 7'h73, 7'h0F, 7'h0B,
                           7'h7F};

  initial begin
    logic [31:0] ins;
    logic [31:0] wv;
    cur = zero_e(1);
    regs[0] = 32'h0;
    repeat (2) @(posedge clk);
    // Fill the regfile under reset; these writes must still land
    for (int k = 1; k < 32; k++) begin
      wv = $urandom;
      step(32'h13, 32'h0, 1'b0, 1'b0, 1'b1, 5'(k), wv, 1'b1);
    end
    // addi x1,x0,5
    issue(32'h00500093, 1'b0, 1'b0, 5'd0, 32'h0);
    // add x3,x2,x2 with same-cycle write of x2
    issue(enc_r(5'd3, 5'd2, 5'd2), 1'b0, 1'b1, 5'd2, 32'd7);
    // write to x0 ignored, bypass must not apply
    issue(enc_r(5'd7, 5'd0, 5'd0), 1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
    issue(enc_r(5'd8, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 32'h0);
    // load-use: lw x5,0(x1); add x6,x5,x0
    issue(enc_i(12'h0, 5'd1, 3'd2, 5'd5, 7'h03), 1'b0, 1'b0, 5'd0, 0);
    issue(enc_r(5'd6, 5'd5, 5'd0), 1'b0, 1'b0, 5'd0, 32'h0);
    // load-use with flush in the same cycle
    issue(enc_i(12'h0, 5'd1, 3'd2, 5'd5, 7'h03), 1'b0, 1'b0, 5'd0, 0);
    issue(enc_r(5'd6, 5'd5, 5'd0), 1'b1, 1'b0, 5'd0, 32'h0);
    issue(32'h13, 1'b0, 1'b0, 5'd0, 32'h0);
    // beq, jal, illegal
    issue(32'hFE000EE3, 1'b0, 1'b0, 5'd0, 32'h0);
    issue(32'h008000EF, 1'b0, 1'b0, 5'd0, 32'h0);
    issue(32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 32'h0);
    // stallIn holds all outputs across 3 edges
    for (int k = 0; k < 3; k++)
      step(32'h00500093, pcv, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    issue(32'h00500093, 1'b0, 1'b0, 5'd0, 32'h0);
    // Random stream; fetch holds the instruction whenever stalled
    ins = 32'h13;
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) begin
        ins = $urandom;
        ins[6:0] = ops[$urandom_range(0, 12)];
        ins[11:7] = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        if (n % 5 == 0) ins[6:0] = 7'h03;
        pcv += 4;
      end
      step(ins, pcv, $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)), $urandom, 1'b0);
    end
    step(32'h13, pcv, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    repeat (3) @(posedge clk);
    #9;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
